// File: rtl/serial_to_parallel_pkg.sv
// Shared types for the serial_to_parallel deserializer: collector FSM states
// and the helper that sizes its counters.
package serial_to_parallel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } s2p_state_t;

  // Bits needed to hold any value 0..max_count (never less than one bit).
  function automatic int unsigned count_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// One-entry valid/ready output register for the deserializer; a word that
// completes while the held word is still waiting is dropped and flagged.
module s2p_out_reg
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic             overflow
);

  logic can_load;

  // The slot is free if empty or if its word is being taken this cycle.
  assign can_load = ~valid | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= load & ~can_load;
      if (load && can_load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel deserializer with gap timeout and overflow flag.
// Define SERIAL_TO_PARALLEL_PARITY_EN to append and check an even-parity bit per frame.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned width     = 8,
  parameter int unsigned gap_limit = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             parallel_valid,
  input  logic             parallel_ready,
  output logic [width-1:0] parallel_data,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int unsigned CW = count_width(width);

  s2p_state_t       state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [width-1:0] shift, shift_next, shift_ins;
  logic             complete;
  logic             timeout;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  logic             parity_bad;
`endif

  assign busy = (state != IDLE);

  // Current shift register with the incoming bit placed at index count.
  // In PARITY count equals width, so this is the unchanged data word.
  always_comb begin
    shift_ins = shift;
    for (int i = 0; i < width; i++) begin
      if (count == CW'(i)) shift_ins[i] = serial_data;
    end
  end

  generate
    if (gap_limit > 0) begin : g_gap
      localparam int unsigned GW = count_width(gap_limit);
      logic [GW-1:0] idle_cnt;

      assign timeout = busy & ~serial_valid & (idle_cnt == GW'(gap_limit - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          idle_cnt <= '0;
        end else if (!busy || serial_valid || timeout) begin
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end else begin : g_no_gap
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      shift     <= shift_next;
      frame_err <= timeout;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    shift_next = shift;
    complete   = 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    parity_bad = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (serial_valid) begin
          shift_next = {{(width-1){1'b0}}, serial_data};
          count_next = CW'(1);
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (timeout) begin
          count_next = '0;
          state_next = IDLE;
        end else if (serial_valid) begin
          shift_next = shift_ins;
          if (count == CW'(width - 1)) begin
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            count_next = CW'(width);
            state_next = PARITY;
`else
            complete   = 1'b1;
            count_next = '0;
            state_next = IDLE;
`endif
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      PARITY: begin
        if (timeout) begin
          count_next = '0;
          state_next = IDLE;
        end else if (serial_valid) begin
          if (((^shift) ^ serial_data) == 1'b0) complete   = 1'b1;
          else                                  parity_bad = 1'b1;
          count_next = '0;
          state_next = IDLE;
        end
      end
`endif
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= parity_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

  s2p_out_reg #(
    .width(width)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (complete),
    .load_data(shift_ins),
    .ready    (parallel_ready),
    .valid    (parallel_valid),
    .data     (parallel_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: directed scenarios plus random
// serial traffic, all checked against a frame-level reference model.
module tb_serial_to_parallel;

  localparam int W   = 8;
  localparam int GAP = 4;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         serial_valid, serial_data, parallel_ready;
  logic         parallel_valid, busy, overflow, frame_err, parity_err;
  logic [W-1:0] parallel_data;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: bits of the frame in flight plus the expected outputs.
  bit           bit_q[$];
  int           gap_cnt;
  logic         exp_valid, exp_busy, exp_ovf, exp_ferr, exp_perr;
  logic [W-1:0] exp_data;

  serial_to_parallel #(
    .width    (W),
    .gap_limit(GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .serial_valid  (serial_valid),
    .serial_data   (serial_data),
    .parallel_valid(parallel_valid),
    .parallel_ready(parallel_ready),
    .parallel_data (parallel_data),
    .busy          (busy),
    .overflow      (overflow),
    .frame_err     (frame_err),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    bit_q.delete();
    gap_cnt   = 0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    exp_ovf   = 1'b0;
    exp_ferr  = 1'b0;
    exp_perr  = 1'b0;
    exp_data  = '0;
  endtask

  // Advance the model by one clock with the given inputs.
  task automatic modelStep(input bit v, input bit d, input bit r);
    bit           completed = 0;
    bit           par = 0;
    logic [W-1:0] w = '0;
    logic         nv = exp_valid;
    logic [W-1:0] nd = exp_data;
    logic         novf = 1'b0, nferr = 1'b0, nperr = 1'b0;
    if (v) begin
      bit_q.push_back(d);
      gap_cnt = 0;
      if (bit_q.size() == FRAME) begin
        for (int i = 0; i < W; i++) w[i] = bit_q[i];
        foreach (bit_q[j]) par ^= bit_q[j];
        if (FRAME == W || par == 0) completed = 1;
        else                        nperr = 1'b1;
        bit_q.delete();
      end
    end else if (bit_q.size() > 0) begin
      gap_cnt++;
      if (gap_cnt == GAP) begin
        bit_q.delete();
        gap_cnt = 0;
        nferr   = 1'b1;
      end
    end
    if (completed) begin
      if (!exp_valid || r) begin
        nv = 1'b1;
        nd = w;
      end else begin
        novf = 1'b1;
      end
    end else if (exp_valid && r) begin
      nv = 1'b0;
    end
    exp_valid = nv;
    exp_data  = nd;
    exp_ovf   = novf;
    exp_ferr  = nferr;
    exp_perr  = nperr;
    exp_busy  = (bit_q.size() > 0);
  endtask

  // At the falling edge: check current outputs, then drive the next inputs.
  task automatic applyStimulus(input bit v, input bit d, input bit r);
    @(negedge clk);
    checkOutput("valid", parallel_valid, exp_valid);
    if (exp_valid) checkOutput("data", parallel_data, exp_data);
    checkOutput("busy", busy, exp_busy);
    checkOutput("overflow", overflow, exp_ovf);
    checkOutput("frame_err", frame_err, exp_ferr);
    checkOutput("parity_err", parity_err, exp_perr);
    serial_valid   = v;
    serial_data    = d;
    parallel_ready = r;
    modelStep(v, d, r);
  endtask

  task automatic sendWord(input logic [W-1:0] word, input bit r);
    for (int i = 0; i < W; i++) applyStimulus(1'b1, word[i], r);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    applyStimulus(1'b1, ^word, r);
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n          = 1'b0;
    serial_valid   = 1'b0;
    serial_data    = 1'b0;
    parallel_ready = 1'b0;
    #1;
    checkOutput("rst_valid", parallel_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_data", parallel_data, '0);
    checkOutput("rst_flags", {overflow, frame_err, parity_err}, 3'b000);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    rst_n          = 1'b0;
    serial_valid   = 1'b0;
    serial_data    = 1'b0;
    parallel_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_valid", parallel_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_data", parallel_data, '0);
    rst_n = 1'b1;

    // Single word, busy for the seven cycles after the first bit
    sendWord(8'hA5, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_valid", parallel_valid, 1'b1);
    checkOutput("t1_data", parallel_data, 8'hA5);

    // Back-to-back words
    sendWord(8'h3C, 1'b1);
    sendWord(8'hC3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t2_data", parallel_data, 8'hC3);
    checkOutput("t2_ovf", overflow, 1'b0);

    // Overflow while output is held
    sendWord(8'h01, 1'b0);
    sendWord(8'hFF, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_data", parallel_data, 8'h01);
    checkOutput("t3_ovf", overflow, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_ovf_once", overflow, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_drained", parallel_valid, 1'b0);

    // Gap timeout on a partial frame, then a clean frame
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < GAP; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_ferr", frame_err, 1'b1);
    checkOutput("t4_busy", busy, 1'b0);
    sendWord(8'h5A, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_data", parallel_data, 8'h5A);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    doReset();
    sendWord(8'h81, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_data", parallel_data, 8'h81);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    sendWord(8'h07, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_good", {parallel_valid, parallel_data}, {1'b1, 8'h07});
    w = 8'h07;
    for (int i = 0; i < W; i++) applyStimulus(1'b1, w[i], 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_perr", parity_err, 1'b1);
    checkOutput("t6_novalid", parallel_valid, 1'b0);
`endif

    // Random traffic with occasional long gaps
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        w = W'($urandom_range(3, 6));
        for (int g = 0; g < int'(w); g++) applyStimulus(1'b0, 1'b0, $urandom_range(0, 99) < 60);
      end
      applyStimulus($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 99) < 60);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
